// File: rtl/wb_pkg.sv
// Shared widths, drain-state encoding and entry record for the posted-write buffer.
package wb_pkg;

  localparam int unsigned ADR_W_DEF  = 30;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BE_W_DEF   = DATA_W_DEF / 8;

  // One byte enable per 8-bit data lane.
  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Drain state; the BUSY state is exactly mem_en.
  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_BUSY = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [ADR_W_DEF-1:0]  adr;
    logic [DATA_W_DEF-1:0] data;
    logic [BE_W_DEF-1:0]   byteen;
    logic                  valid;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_mux.sv
// Per-lane read forwarding: the youngest valid matching entry supplies each byte.
module wb_fwd_mux
  import wb_pkg::*;
#(
  parameter int unsigned ADR_W  = ADR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned BE_W  = be_width(DATA_W),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [ADR_W-1:0]  adr_i    [DEPTH],
  input  logic [DATA_W-1:0] data_i   [DEPTH],
  input  logic [BE_W-1:0]   byteen_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [PTR_W-1:0]  head_i,
  input  logic [ADR_W-1:0]  rd_adr_i,
  output logic              rd_hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [BE_W-1:0]   rd_byteen_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so later (younger) entries overwrite earlier lanes.
  always_comb begin
    rd_data_o   = '0;
    rd_byteen_o = '0;
    idx         = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = head_i + PTR_W'(k);
      if (valid_i[idx] && (adr_i[idx] == rd_adr_i)) begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (byteen_i[idx][b]) begin
            rd_data_o[8*b +: 8] = data_i[idx][8*b +: 8];
            rd_byteen_o[b]      = 1'b1;
          end
        end
      end
    end
  end

  assign rd_hit_o = |rd_byteen_o;

endmodule

// File: rtl/param_write_buffer.sv
// Posted-write buffer: coalesces into the youngest entry, forwards reads,
// and drains in order to memory over a single-outstanding en/done handshake.
module param_write_buffer
  import wb_pkg::*;
#(
  parameter int unsigned ADR_W    = ADR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter bit          MERGE_EN = 1'b1,
  localparam int unsigned BE_W    = be_width(DATA_W),
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADR_W-1:0]  wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_byteen,
  output logic              wr_ack,
  input  logic [ADR_W-1:0]  rd_adr,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic [BE_W-1:0]   rd_byteen,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_data,
  output logic [BE_W-1:0]   mem_byteen,
  output logic              mem_en,
  input  logic              mem_done,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [ADR_W-1:0]  adr_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, tail_q, young;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  drain_state_e      state_q;
  logic [ADR_W-1:0]  mem_adr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [BE_W-1:0]   mem_be_q;

  logic              merge_hit_c, do_wr, do_push, do_merge, do_issue, do_pop;
  logic [DATA_W-1:0] merged_data, iss_data;
  logic [BE_W-1:0]   merged_be, iss_be;

  assign young       = tail_q - PTR_W'(1);
  assign merge_hit_c = MERGE_EN && (count_q != '0) && valid_q[young] &&
                       (adr_q[young] == wr_adr) &&
                       !((state_q == DRAIN_BUSY) && (young == head_q));
  assign wr_ack      = wr_en && (!full_q || merge_hit_c);
  assign do_wr       = wr_ack && (wr_byteen != '0);
  assign do_merge    = do_wr && merge_hit_c;
  assign do_push     = do_wr && !merge_hit_c;
  assign do_issue    = (state_q == DRAIN_IDLE) && (count_q != '0);
  assign do_pop      = (state_q == DRAIN_BUSY) && mem_done;

  // Merged image of the youngest entry; also issued if that entry leaves this edge.
  always_comb begin
    merged_data = data_q[young];
    for (int b = 0; b < int'(BE_W); b++) begin
      if (wr_byteen[b]) merged_data[8*b +: 8] = wr_data[8*b +: 8];
    end
    merged_be = be_q[young] | wr_byteen;
    iss_data  = data_q[head_q];
    iss_be    = be_q[head_q];
    if (do_merge && (young == head_q)) begin
      iss_data = merged_data;
      iss_be   = merged_be;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      state_q    <= DRAIN_IDLE;
      mem_adr_q  <= '0;
      mem_data_q <= '0;
      mem_be_q   <= '0;
    end else begin
      if (do_push) begin
        adr_q[tail_q]   <= wr_adr;
        data_q[tail_q]  <= wr_data;
        be_q[tail_q]    <= wr_byteen;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (do_merge) begin
        data_q[young] <= merged_data;
        be_q[young]   <= merged_be;
      end
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
      case (state_q)
        DRAIN_IDLE: if (do_issue) begin
          state_q    <= DRAIN_BUSY;
          mem_adr_q  <= adr_q[head_q];
          mem_data_q <= iss_data;
          mem_be_q   <= iss_be;
        end
        DRAIN_BUSY: if (mem_done) state_q <= DRAIN_IDLE;
        default:    state_q <= DRAIN_IDLE;
      endcase
    end
  end

  assign mem_en     = (state_q == DRAIN_BUSY);
  assign mem_adr    = mem_adr_q;
  assign mem_data   = mem_data_q;
  assign mem_byteen = mem_be_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;

  wb_fwd_mux #(
    .ADR_W  (ADR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fwd (
    .adr_i       (adr_q),
    .data_i      (data_q),
    .byteen_i    (be_q),
    .valid_i     (valid_q),
    .head_i      (head_q),
    .rd_adr_i    (rd_adr),
    .rd_hit_o    (rd_hit),
    .rd_data_o   (rd_data),
    .rd_byteen_o (rd_byteen)
  );

endmodule
